// File: rtl/ex_stage_pkg.sv
// Shared constants and types for the execute stage and its iterative divider.
package ex_stage_pkg;

    localparam int ID_TO_EX_WD  = 159;
    localparam int EX_TO_MEM_WD = 141;
    localparam int EX_TO_ID_WD  = 44;
    localparam int STALL_WD     = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // alu_op bit positions, MSB first
    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] FUNC_DIV   = 6'h1A;
    localparam logic [5:0] FUNC_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  sel_alu_src1;
        logic [3:0]  sel_alu_src2;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
    } id_to_ex_t;

    function automatic logic is_div_inst(input logic [31:0] inst);
        return (inst[31:26] == OP_SPECIAL) &&
               ((inst[5:0] == FUNC_DIV) || (inst[5:0] == FUNC_DIVU));
    endfunction

endpackage

// File: rtl/ex_stage_div_iter.sv
// 32-step restoring divider: magnitudes in, sign fix-up applied on the DONE outputs.
module div_iter
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    input  logic        ack,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_t  state_reg, state_next;
    logic [4:0]  count_reg;
    logic [31:0] quo_reg, rem_reg, divisor_reg;
    logic        neg_q_reg, neg_r_reg, zero_reg;

    logic [31:0] abs_a, abs_b;
    logic [32:0] trial, diff;
    logic        fits;

    assign abs_a = (signed_op && op_a[31]) ? (32'd0 - op_a) : op_a;
    assign abs_b = (signed_op && op_b[31]) ? (32'd0 - op_b) : op_b;

    assign trial = {rem_reg, quo_reg[31]};
    assign diff  = trial - {1'b0, divisor_reg};
    assign fits  = ~diff[32];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= DIV_IDLE;
            count_reg   <= 5'd0;
            quo_reg     <= 32'd0;
            rem_reg     <= 32'd0;
            divisor_reg <= 32'd0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            zero_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                DIV_IDLE: if (start) begin
                    quo_reg     <= abs_a;
                    rem_reg     <= 32'd0;
                    divisor_reg <= abs_b;
                    neg_q_reg   <= signed_op & (op_a[31] ^ op_b[31]);
                    neg_r_reg   <= signed_op & op_a[31];
                    zero_reg    <= (op_b == 32'd0);
                    count_reg   <= 5'd0;
                end
                DIV_BUSY: begin
                    quo_reg   <= {quo_reg[30:0], fits};
                    rem_reg   <= fits ? diff[31:0] : trial[31:0];
                    count_reg <= count_reg + 5'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            DIV_IDLE: if (start) begin
                busy       = 1'b1;
                state_next = DIV_BUSY;
            end
            DIV_BUSY: begin
                busy = 1'b1;
                if (count_reg == 5'd31) state_next = DIV_DONE;
            end
            DIV_DONE: begin
                done = 1'b1;
                if (ack) state_next = DIV_IDLE;
            end
            default: state_next = DIV_IDLE;
        endcase
    end

    // A zero divisor leaves the raw shift-subtract result untouched.
    assign quotient  = (neg_q_reg && !zero_reg) ? (32'd0 - quo_reg) : quo_reg;
    assign remainder = (neg_r_reg && !zero_reg) ? (32'd0 - rem_reg) : rem_reg;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: pipeline register, operand select, ALU, data SRAM request and divider.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    output logic                    stallreq_for_ex,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata
);

    id_to_ex_t   ex_reg;
    logic [31:0] src1, src2, ex_result;
    logic [31:0] imm_sext, imm_zext;
    logic [4:0]  shamt;
    logic        div_busy, div_done;
    logic [31:0] div_q, div_r;
    logic [31:0] hi, lo;
    logic        unused_stall;

    assign unused_stall = ^{stall[5:4], stall[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_reg <= '0;
        end else if (stall[2] == STOP && stall[3] == NO_STOP) begin
            ex_reg <= '0;
        end else if (stall[2] == NO_STOP) begin
            ex_reg <= id_to_ex_bus;
        end
    end

    assign imm_sext = {{16{ex_reg.inst[15]}}, ex_reg.inst[15:0]};
    assign imm_zext = {16'd0, ex_reg.inst[15:0]};

    assign src1 = ({32{ex_reg.sel_alu_src1[0]}} & ex_reg.rdata1)
                | ({32{ex_reg.sel_alu_src1[1]}} & ex_reg.pc)
                | ({32{ex_reg.sel_alu_src1[2]}} & {27'd0, ex_reg.inst[10:6]});

    assign src2 = ({32{ex_reg.sel_alu_src2[0]}} & ex_reg.rdata2)
                | ({32{ex_reg.sel_alu_src2[1]}} & imm_sext)
                | ({32{ex_reg.sel_alu_src2[2]}} & 32'd8)
                | ({32{ex_reg.sel_alu_src2[3]}} & imm_zext);

    assign shamt = src1[4:0];

    // alu_op is one-hot; OR-ing masked results yields 0 when no op is selected.
    always_comb begin
        ex_result = 32'd0;
        if (ex_reg.alu_op[ALU_ADD])  ex_result = ex_result | (src1 + src2);
        if (ex_reg.alu_op[ALU_SUB])  ex_result = ex_result | (src1 - src2);
        if (ex_reg.alu_op[ALU_SLT])  ex_result = ex_result | {31'd0, $signed(src1) < $signed(src2)};
        if (ex_reg.alu_op[ALU_SLTU]) ex_result = ex_result | {31'd0, src1 < src2};
        if (ex_reg.alu_op[ALU_AND])  ex_result = ex_result | (src1 & src2);
        if (ex_reg.alu_op[ALU_NOR])  ex_result = ex_result | ~(src1 | src2);
        if (ex_reg.alu_op[ALU_OR])   ex_result = ex_result | (src1 | src2);
        if (ex_reg.alu_op[ALU_XOR])  ex_result = ex_result | (src1 ^ src2);
        if (ex_reg.alu_op[ALU_SLL])  ex_result = ex_result | (src2 << shamt);
        if (ex_reg.alu_op[ALU_SRL])  ex_result = ex_result | (src2 >> shamt);
        if (ex_reg.alu_op[ALU_SRA])  ex_result = ex_result | 32'($signed(src2) >>> shamt);
        if (ex_reg.alu_op[ALU_LUI])  ex_result = ex_result | {src2[15:0], 16'd0};
    end

    div_iter u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div_inst(ex_reg.inst)),
        .signed_op (ex_reg.inst[5:0] == FUNC_DIV),
        .op_a      (ex_reg.rdata1),
        .op_b      (ex_reg.rdata2),
        .busy      (div_busy),
        .done      (div_done),
        .ack       (stall[3] == NO_STOP),
        .quotient  (div_q),
        .remainder (div_r)
    );

    assign stallreq_for_ex = div_busy;
    assign hi = div_done ? div_r : 32'd0;
    assign lo = div_done ? div_q : 32'd0;

    assign data_sram_en    = ex_reg.data_ram_en;
    assign data_sram_wen   = ex_reg.data_ram_wen;
    assign data_sram_addr  = ex_result;
    assign data_sram_wdata = ex_reg.rdata2;

    assign ex_to_mem_bus = {ex_reg.pc, ex_reg.data_ram_en, ex_reg.data_ram_wen,
                            ex_reg.sel_rf_res, ex_reg.rf_we, ex_reg.rf_waddr,
                            ex_result, div_done, hi, lo};

    assign ex_to_id_bus = {ex_reg.rf_we, ex_reg.rf_waddr, ex_result, ex_reg.inst[31:26]};

endmodule
